usr_sequencer: RTL and testbench

Command-driven controller for the 4-bit universal shift register (univ_shift_register). Accepts one command per valid/ready handshake (optional parallel load followed by N shift/rotate steps) and drives the register's control and data inputs cycle by cycle. Signals completion with a one-cycle done pulse. Sits between a host/test sequencer and the register; the register's Q is not read by this block.

---
 rtl/usr_pkg.sv | 24 ++
 rtl/usr_step_counter.sv | 37 +++
 rtl/usr_sequencer.sv | 152 +++++++++++++++
 tb/tb_usr_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal-shift-register sequencer: control codes,
// sequencer states and the shift/rotate classifier.
package usr_pkg;

  localparam logic [2:0] HOLD = 3'b000;
  localparam logic [2:0] SHR  = 3'b001;
  localparam logic [2:0] SHL  = 3'b010;
  localparam logic [2:0] LOAD = 3'b011;
  localparam logic [2:0] ROR  = 3'b100;
  localparam logic [2:0] ROL  = 3'b101;
  localparam logic [2:0] CLR  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_STEP = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == SHR) || (op == SHL) || (op == ROR) || (op == ROL);
  endfunction

endpackage

// File: rtl/usr_step_counter.sv
// Loadable down-counter holding the number of shift/rotate steps still to issue.
// last_o is high once every step has been issued; the count never goes below zero.
module usr_step_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          last_o
);

  logic [CW-1:0] count_q, count_d;

  // NOTE: count_d gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == '0);

endmodule

// File: rtl/usr_sequencer.sv
// Command-driven controller for the 4-bit universal shift register: optional parallel
// load, then N shift/rotate steps, then a one-cycle done pulse. All outputs registered.
module usr_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_load,
  input  logic [CW-1:0]    cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             stall,
  output logic [2:0]       usr_control,
  output logic [WIDTH-1:0] usr_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       usr_control_q, usr_control_d;
  logic [WIDTH-1:0] usr_data_q, usr_data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cnt_load;
  logic [CW-1:0]    cnt_load_val;
  logic             cnt_en;
  logic             cnt_last;

  usr_step_counter #(.CW(CW)) u_step_counter (
    .clk       (clk),
    .reset     (reset),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .en_i      (cnt_en),
    .last_o    (cnt_last)
  );

  // The counter holds steps not yet issued; a step issued on the same edge as
  // the counter load is already subtracted from the loaded value.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    usr_control_d = HOLD;
    usr_data_d    = usr_data_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    cnt_load      = 1'b0;
    cnt_load_val  = '0;
    cnt_en        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          if (is_shift_op(cmd_op)) begin
            if (cmd_load) begin
              state_d       = S_LOAD;
              usr_control_d = LOAD;
              usr_data_d    = cmd_data;
              cnt_load      = 1'b1;
              cnt_load_val  = cmd_count;
            end else if (cmd_count != '0) begin
              state_d       = S_STEP;
              usr_control_d = cmd_op;
              cnt_load      = 1'b1;
              cnt_load_val  = cmd_count - CW'(1);
            end else begin
              state_d = S_FIN;
              done_d  = 1'b1;
            end
          end else if (cmd_op == LOAD) begin
            state_d       = S_LOAD;
            usr_control_d = LOAD;
            usr_data_d    = cmd_data;
            cnt_load      = 1'b1;
          end else if (cmd_op == CLR) begin
            state_d       = S_STEP;
            usr_control_d = CLR;
            cnt_load      = 1'b1;
          end else begin
            state_d = S_FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (is_shift_op(op_q) && !cnt_last) begin
          state_d       = S_STEP;
          usr_control_d = op_q;
          cnt_en        = 1'b1;
        end else begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end
      end

      S_STEP: begin
        if (cnt_last) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else if (!stall) begin
          usr_control_d = op_q;
          cnt_en        = 1'b1;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      op_q          <= HOLD;
      usr_control_q <= HOLD;
      usr_data_q    <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      usr_control_q <= usr_control_d;
      usr_data_q    <= usr_data_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign usr_control = usr_control_q;
  assign usr_data    = usr_data_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_usr_sequencer.sv
// Self-checking bench for usr_sequencer: a queue-based model expands each accepted
// command into its expected per-cycle outputs; a small register model tracks Q.
module tb_usr_sequencer;
  import usr_pkg::*;

  localparam int WIDTH = 4;
  localparam int CW    = 4;

  typedef struct packed {
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] data;
    logic             busy;
    logic             done;
    logic             err;
    logic             ready;
  } obs_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = HOLD;
  logic             cmd_load = 1'b0;
  logic [CW-1:0]    cmd_count = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             stall = 1'b0;
  logic [2:0]       usr_control;
  logic [WIDTH-1:0] usr_data;
  logic             busy, done, err;

  always #5 clk = ~clk;

  usr_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_load   (cmd_load),
    .cmd_count  (cmd_count),
    .cmd_data   (cmd_data),
    .stall      (stall),
    .usr_control(usr_control),
    .usr_data   (usr_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  obs_t        exp_q[$];
  logic [WIDTH-1:0] m_data = '0;
  logic [63:0] m_seq = '0;
  logic [63:0] pend_mask = '0;
  logic [63:0] act_mask = '0;
  logic        idle_stall = 1'b0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          n_acc = 0;
  int          done_off = -1;
  logic        err_at_done = 1'b0;
  logic [WIDTH-1:0] q_reg = '0;
  obs_t        a_obs, e_obs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expands one command into its expected output cycles T+1, T+2, ...
  // A step slot becomes a HOLD gap only when stall was high in the previous
  // cycle and that cycle was itself a step or gap cycle.
  function automatic void build(input logic [2:0] op, input logic ld, input logic [CW-1:0] n,
                                input logic [WIDTH-1:0] d, input logic [63:0] mask);
    int   k = 1;
    int   left;
    bit   first = 1'b1;
    bit   is_sh = (op == SHR) || (op == SHL) || (op == ROR) || (op == ROL);
    obs_t e;
    m_seq = '0;
    e = '{ctrl: HOLD, data: m_data, busy: 1'b1, done: 1'b0, err: 1'b0, ready: 1'b0};
    if (!(is_sh || op == LOAD || op == CLR)) begin
      e.done = 1'b1;
      e.err  = 1'b1;
      exp_q.push_back(e);
      m_seq = {m_seq[60:0], e.ctrl};
      return;
    end
    if (op == LOAD || (ld && is_sh)) begin
      m_data = d;
      e.data = d;
      e.ctrl = LOAD;
      exp_q.push_back(e);
      m_seq = {m_seq[60:0], e.ctrl};
      k++;
    end
    left = (op == CLR) ? 1 : (is_sh ? int'(n) : 0);
    while (left > 0) begin
      if (!first && k - 1 < 64 && mask[k-1]) begin
        e.ctrl = HOLD;
      end else begin
        e.ctrl = op;
        left--;
      end
      exp_q.push_back(e);
      m_seq = {m_seq[60:0], e.ctrl};
      k++;
      first = 1'b0;
    end
    e.ctrl = HOLD;
    e.done = 1'b1;
    exp_q.push_back(e);
    m_seq = {m_seq[60:0], e.ctrl};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_data   = '0;
      act_mask = '0;
    end else begin
      cyc++;
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end else if (cmd_valid) begin
        act_mask = pend_mask;
        build(cmd_op, cmd_load, cmd_count, cmd_data, pend_mask);
        acc_cyc = cyc;
        n_acc++;
      end
    end
  end

  // Reference shift register driven by the sequencer outputs (serial-in 0).
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= '0;
    end else begin
      case (usr_control)
        SHR:     q_reg <= {1'b0, q_reg[3:1]};
        SHL:     q_reg <= {q_reg[2:0], 1'b0};
        LOAD:    q_reg <= usr_data;
        ROR:     q_reg <= {q_reg[0], q_reg[3:1]};
        ROL:     q_reg <= {q_reg[2:0], q_reg[3]};
        CLR:     q_reg <= '0;
        default: q_reg <= q_reg;
      endcase
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      stall = act_mask[(cyc - acc_cyc + 1) & 63];
    end else begin
      stall = idle_stall;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      a_obs = '{ctrl: usr_control, data: usr_data, busy: busy, done: done, err: err, ready: cmd_ready};
      if (exp_q.size() != 0) begin
        e_obs = exp_q[0];
      end else begin
        e_obs = '{ctrl: HOLD, data: m_data, busy: 1'b0, done: 1'b0, err: 1'b0, ready: 1'b1};
      end
      check($sformatf("obs{ctrl,data,busy,done,err,ready} cycle %0d", cyc), 32'(a_obs), 32'(e_obs));
      if (done) begin
        done_off    = cyc - acc_cyc + 1;
        err_at_done = err;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic ld, input logic [CW-1:0] n,
                      input logic [WIDTH-1:0] d, input logic [63:0] mask);
    int start = n_acc;
    cmd_op    = op;
    cmd_load  = ld;
    cmd_count = n;
    cmd_data  = d;
    pend_mask = mask;
    cmd_valid = 1'b1;
    for (int i = 0; i < 60 && n_acc == start; i++) @(negedge clk);
    if (n_acc == start) check("accept_timeout", 32'(n_acc), 32'(start + 1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) check("done_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run(input logic [2:0] op, input logic ld, input logic [CW-1:0] n,
                     input logic [WIDTH-1:0] d, input logic [63:0] mask);
    done_off = -1;
    send(op, ld, n, d, mask);
    cmd_valid = 1'b0;
    wait_idle();
  endtask

  logic [WIDTH-1:0] q_pre;
  int               acc_first;

  initial begin
    #1;
    check("reset_ctrl", 32'(usr_control), 32'd0);
    check("reset_data", 32'(usr_data), 32'd0);
    check("reset_busy_done_err", 32'({busy, done, err}), 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Load 1010 then three right shifts.
    run(SHR, 1'b1, 4'd3, 4'b1010, 64'd0);
    check("shr_model_seq", m_seq[31:0], 32'(15'b011_001_001_001_000));
    check("shr_done_offset", 32'(done_off), 32'd5);
    check("shr_q", 32'(q_reg), 32'b0001);

    // Four rotates left with a two-cycle stall during step 2.
    q_pre = q_reg;
    run(ROL, 1'b0, 4'd4, 4'b0000, 64'b110);
    check("rol_model_seq", m_seq[31:0], 32'(21'b101_000_000_101_101_101_000));
    check("rol_done_offset", 32'(done_off), 32'd7);
    check("rol_q_restored", 32'(q_reg), 32'(q_pre));

    // Plain load; count is ignored.
    run(LOAD, 1'b0, 4'd9, 4'b1111, 64'd0);
    check("load_model_seq", m_seq[31:0], 32'(6'b011_000));
    check("load_done_offset", 32'(done_off), 32'd2);
    check("load_err", 32'(err_at_done), 32'd0);
    check("load_q", 32'(q_reg), 32'b1111);

    // Zero-step shift and illegal ops; stall is ignored in IDLE and FIN.
    idle_stall = 1'b1;
    run(SHL, 1'b0, 4'd0, 4'b0101, {64{1'b1}});
    idle_stall = 1'b0;
    check("shl0_done_offset", 32'(done_off), 32'd1);
    check("shl0_err", 32'(err_at_done), 32'd0);
    check("shl0_q", 32'(q_reg), 32'b1111);
    run(3'b111, 1'b0, 4'd5, 4'b0000, 64'd0);
    check("ill_done_offset", 32'(done_off), 32'd1);
    check("ill_err", 32'(err_at_done), 32'd1);
    run(HOLD, 1'b1, 4'd2, 4'b0011, 64'd0);
    check("hold_err", 32'(err_at_done), 32'd1);

    // Back-to-back CLR then LOAD 1000 with cmd_valid held high.
    done_off = -1;
    send(CLR, 1'b0, 4'd7, 4'b0000, 64'd0);
    acc_first = acc_cyc;
    send(LOAD, 1'b0, 4'd0, 4'b1000, 64'd0);
    check("b2b_accept_gap", 32'(acc_cyc - acc_first), 32'd3);
    check("b2b_q_after_clr", 32'(q_reg), 32'b0000);
    cmd_valid = 1'b0;
    wait_idle();
    check("b2b_q_after_load", 32'(q_reg), 32'b1000);

    // Max count with load; stall during LOAD ignored, two stall gaps later.
    run(ROR, 1'b1, 4'd15, 4'b0110, 64'b110_0010);
    check("ror15_done_offset", 32'(done_off), 32'd19);
    check("ror15_q", 32'(q_reg), 32'b1100);

    // Reset in the middle of a long command: no done pulse follows.
    done_off = -1;
    send(SHR, 1'b0, 4'd15, 4'b0000, 64'd0);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_ctrl", 32'(usr_control), 32'd0);
    check("abort_data", 32'(usr_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_off), 32'hffff_ffff);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
